lsu_rv32i: RTL and testbench
============================

# lsu_rv32i

Load/store unit for the RV32I core, sitting between the execute stage and the data-memory port, with its writeback output feeding the register file. It accepts one load or store at a time over a valid/ready handshake. It handles RV32I byte, halfword and word access: byte-enable generation, lane shifting, and sign/zero extension. It rejects misaligned or illegal accesses and bounds memory latency with a timeout. All widths come from `riscv_32i_defs_pkg` (`XLEN`, `word_t`, `rf_addr_t`, `X0`).

## Interface
- `MEM_TIMEOUT`, 16: cycles spent in WAIT without `mem_rvalid` before the load is aborted with error; must be ≥1.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; asserted only in IDLE.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- `req_addr` in XLEN: byte address, already computed as base + offset.
- `req_wdata` in XLEN: store data from rs2.
- `req_rd` in RF_ADDR_WIDTH: load destination register.
- `mem_req` out 1: memory request, held until granted.
- `mem_we` out 1: write enable.
- `mem_addr` out XLEN: word-aligned address; `req_addr` with bits [1:0] forced to 00.
- `mem_be` out 4: byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_wdata` out XLEN: lane-placed store data.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in XLEN: read data word.
- `wb_valid` out 1: one-cycle completion pulse.
- `wb_rd` out RF_ADDR_WIDTH: destination register; forced to X0 for stores and errors.
- `wb_data` out XLEN: extended load data; 0 for stores and errors.
- `wb_err` out 1: access fault, valid with `wb_valid`.

## Operation
- **States:** IDLE, REQ, WAIT, DONE, ERR.
- **IDLE:** `req_ready`=1. On `req_valid`, latch all request fields.
  - Misaligned access (H with `addr[0]`≠0, W with `addr[1:0]`≠00) or illegal funct3 → ERR. No memory access is made.
  - Otherwise → REQ.
- **REQ:** `mem_req`=1, with `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` stable until `mem_gnt`.
  - On `mem_gnt`: store → DONE; load → WAIT with the timeout counter cleared.
  - Waiting for grant is unbounded.
- **WAIT:** the counter increments every cycle without `mem_rvalid`.
  - On `mem_rvalid`: extract and extend the data into `wb_data`, then → DONE.
  - When the counter reaches MEM_TIMEOUT → ERR.
- **DONE:** `wb_valid`=1 for one cycle, then → IDLE.
- **ERR:** `wb_valid`=1 and `wb_err`=1 for one cycle, with `wb_rd`=X0 and `wb_data`=0, then → IDLE.
- **Lane offset** `off = addr[1:0]`:
  - Byte: `mem_be = 4'b0001 << off`; `mem_wdata` = `wdata[7:0]` replicated ×4.
  - Half: `mem_be = 4'b0011 << off`; `mem_wdata` = `wdata[15:0]` replicated ×2.
  - Word: `mem_be = 4'b1111`; `mem_wdata` = `wdata`.
- **Loads:**
  - LB/LBU: sign-/zero-extend `rdata[8*off +: 8]`.
  - LH/LHU: sign-/zero-extend `rdata[8*off +: 16]`.
  - LW: `rdata` unchanged.
  - For loads, `mem_be` and `mem_wdata` use the same rules but are don't-care to memory.
- **Loads to X0:** perform normally; `wb_rd`=X0 and the register file discards the write.
- **Ignored inputs:** `mem_rvalid` outside WAIT, and `mem_gnt` outside REQ.

## Timing
- **Reset values:** state=IDLE; `req_ready`=1 from the first cycle after reset. `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_rd`, `wb_data`, `wb_err` are all 0.
- **Reset mid-operation:** the transaction is abandoned with no `wb_valid`. A late `mem_rvalid` after reset is ignored.
- **Registered outputs:** all outputs are registered except `req_ready`, which decodes state == IDLE.
- **Accept:** at the edge where `req_valid && req_ready`. `req_ready` is 0 in every non-IDLE state, so back-to-back requests are spaced by at least one IDLE cycle.
- **Best-case latency**, with request accepted at edge T:
  - `mem_req` high in cycle T+1.
  - Store granted at T+1 → `wb_valid` in T+2.
  - Load granted at T+1, `rvalid` at T+2 → `wb_valid` in T+3.
- **Error latency:** an error detected at accept → `wb_valid`/`wb_err` in T+1.
- **Timeout:** with no `rvalid`, `wb_err` appears MEM_TIMEOUT+1 cycles after the WAIT entry cycle.
- **Same-cycle timeout and response:** if `mem_rvalid` arrives in the cycle the counter reaches MEM_TIMEOUT, `rvalid` wins and the load completes normally.

## Test plan
- **Reset, then SW:** `addr=0x1000_0006`, `wdata=0xDEAD_BEEF`. Expect ERR: `wb_err`=1, `wb_rd`=0, `wb_data`=0 at T+1, and `mem_req` never asserted.
- **SB:** `addr=0x0000_0103`, `wdata=0x1234_56A5`, `gnt` immediate. Expect `mem_addr=0x100`, `mem_be=1000`, `mem_wdata=0xA5A5_A5A5` at T+1; `wb_valid`, `wb_rd`=0 at T+2.
- **LB / LBU / LH / LHU / LW from `rdata=0x80FF_7F01`:**
  - LB, off 3: `0xFFFF_FF80`.
  - LBU, off 3: `0x0000_0080`.
  - LH, off 2: `0xFFFF_80FF`.
  - LHU, off 0: `0x0000_7F01`.
  - LW: `0x80FF_7F01`.
  - In every case `wb_rd` = `req_rd`.
- **Grant stall:** `mem_gnt` held low 5 cycles. Expect `mem_req`, `mem_addr`, `mem_be` stable throughout; `req_ready`=0; completion follows grant.
- **Load timeout:** `MEM_TIMEOUT=4`, no `rvalid`. Expect `wb_err`=1 exactly 5 cycles after WAIT entry, then `req_ready`=1.
- **Reset mid-WAIT:** assert `rst`, then drive `mem_rvalid`. Expect no `wb_valid`, outputs at reset values, and the next request handled normally.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I widths and types used by the load/store unit and its bus interface.
//   XLEN          : data/address width
//   RF_ADDR_WIDTH : register-file index width
//   word_t        : one XLEN-wide word
//   rf_addr_t     : register index
//   X0            : the hard-wired zero register
package riscv_32i_defs_pkg;
  localparam int XLEN          = 32;
  localparam int RF_ADDR_WIDTH = 5;
  typedef logic [XLEN-1:0]          word_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  localparam rf_addr_t X0 = '0;
endpackage

// File: rtl/lsu_rv32i_if.sv
// Bus bundle for the RV32I load/store unit.
//   req_* : execute-stage request channel (valid/ready handshake)
//   mem_* : data-memory port (request/grant, then read-data valid)
//   wb_*  : register-file writeback pulse
// Modport slave is the LSU's view; modport master is the surrounding
// pipeline/memory environment.
interface lsu_rv32i_if;
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_is_store;
  logic [2:0]                     req_funct3;
  riscv_32i_defs_pkg::word_t      req_addr;
  riscv_32i_defs_pkg::word_t      req_wdata;
  riscv_32i_defs_pkg::rf_addr_t   req_rd;

  logic                           mem_req;
  logic                           mem_we;
  riscv_32i_defs_pkg::word_t      mem_addr;
  logic [3:0]                     mem_be;
  riscv_32i_defs_pkg::word_t      mem_wdata;
  logic                           mem_gnt;
  logic                           mem_rvalid;
  riscv_32i_defs_pkg::word_t      mem_rdata;

  logic                           wb_valid;
  riscv_32i_defs_pkg::rf_addr_t   wb_rd;
  riscv_32i_defs_pkg::word_t      wb_data;
  logic                           wb_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_rd, wb_data, wb_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: takes one load or store at a time from execute,
// drives the data-memory port, and returns a one-cycle writeback pulse.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : lsu_rv32i_if.slave (request, memory and writeback channels)
// Parameter:
//   MEM_TIMEOUT : WAIT cycles without read data before a load faults (>= 1)
// All outputs are registered except req_ready, which decodes the IDLE state.
module lsu_rv32i
  import riscv_32i_defs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  lsu_rv32i_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  rf_addr_t         rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  word_t            mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  word_t            mem_wdata_q, mem_wdata_d;

  logic             wb_valid_q, wb_valid_d;
  rf_addr_t         wb_rd_q, wb_rd_d;
  word_t            wb_data_q, wb_data_d;
  logic             wb_err_q, wb_err_d;

  // Request decode: legality, byte enables and lane-replicated store data.
  logic             req_legal;
  logic [3:0]       req_be;
  word_t            req_lanes;

  always_comb begin
    req_legal = 1'b0;
    req_be    = '0;
    req_lanes = '0;
    case (bus.req_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << bus.req_addr[1:0];
        req_lanes = {4{bus.req_wdata[7:0]}};
        // funct3[2] (unsigned) only exists for loads
        req_legal = !(bus.req_is_store && bus.req_funct3[2]);
      end
      2'b01: begin
        req_be    = 4'b0011 << bus.req_addr[1:0];
        req_lanes = {2{bus.req_wdata[15:0]}};
        req_legal = !(bus.req_is_store && bus.req_funct3[2]) && !bus.req_addr[0];
      end
      2'b10: begin
        req_be    = 4'b1111;
        req_lanes = bus.req_wdata;
        // there is no unsigned word load in RV32I
        req_legal = !bus.req_funct3[2] && (bus.req_addr[1:0] == 2'b00);
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  word_t rdata_shift;
  word_t load_data;

  assign rdata_shift = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = bus.mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
      3'b001:  load_data = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    // writeback fields are pulses: zero unless entering DONE/ERR
    wb_valid_d  = 1'b0;
    wb_err_d    = 1'b0;
    wb_rd_d     = X0;
    wb_data_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          off_d    = bus.req_addr[1:0];
          rd_d     = bus.req_rd;
          if (req_legal) begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_is_store;
            mem_addr_d  = {bus.req_addr[XLEN-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_lanes;
          end else begin
            // faulting access never reaches memory
            state_d    = S_ERR;
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d    = S_DONE;
            wb_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // read data beats the timeout when both land in the same cycle
        if (bus.mem_rvalid) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = S_ERR;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= X0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= X0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_lsu_rv32i.sv
// Directed bench for lsu_rv32i: a transaction-level reference model checks
// every cycle from the negative clock edge; directed cases add literal checks.
module tb_lsu_rv32i;
  import riscv_32i_defs_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_rv32i_if bus();

  lsu_rv32i #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arithmetic from the ISA rules) -------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_legal(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    if (n == 0) return 1'b0;
    if (f3[2] && (st || n == 4)) return 1'b0;
    return (addr % n) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    int off = int'(addr % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    int n = size_of(f3);
    logic [31:0] r = '0;
    if (n == 0) return '0;
    for (int i = 0; i < 4; i++)
      r |= ((wdata >> (8 * (i % n))) & 32'hFF) << (8 * i);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int n = size_of(f3);
    int off = int'(addr % 4);
    longint v = 0;
    for (int k = 0; k < n; k++)
      v |= longint'((rdata >> (8 * (off + k))) & 32'hFF) << (8 * k);
    if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) != 0)
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- cycle compare process ----------------
  bit          m_busy, m_granted, m_wb_due, m_err;
  int          m_wait;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        c_st;
  logic [2:0]  c_f3;
  logic [31:0] c_addr, c_wdata;
  logic [4:0]  c_rd;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_granted = 0; m_wb_due = 0; m_wait = 0;
    end else begin
      check("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      check("wb_valid",  32'(bus.wb_valid),  32'(m_wb_due));
      if (m_wb_due) begin
        check("wb_err",    32'(bus.wb_err),  32'(m_err));
        check("wb_rd",     32'(bus.wb_rd),   32'(m_rd));
        check("wb_data",   bus.wb_data,      m_data);
        check("mem_req_wb", 32'(bus.mem_req), 32'd0);
        m_wb_due = 0;
        m_busy   = 0;
      end else if (m_busy && !m_granted) begin
        check("mem_req",   32'(bus.mem_req), 32'd1);
        check("mem_we",    32'(bus.mem_we),  32'(c_st));
        check("mem_addr",  bus.mem_addr,     c_addr & 32'hFFFF_FFFC);
        check("mem_be",    32'(bus.mem_be),  32'(exp_be(c_f3, c_addr)));
        check("mem_wdata", bus.mem_wdata,    exp_wdata(c_f3, c_wdata));
        if (bus.mem_gnt) begin
          if (c_st) begin
            m_wb_due = 1; m_err = 0; m_rd = '0; m_data = '0;
          end else begin
            m_granted = 1; m_wait = 0;
          end
        end
      end else if (m_busy) begin
        check("mem_req_wait", 32'(bus.mem_req), 32'd0);
        if (bus.mem_rvalid) begin
          m_wb_due = 1; m_err = 0; m_rd = c_rd;
          m_data = exp_load(c_f3, c_addr, bus.mem_rdata);
          m_granted = 0;
        end else if (m_wait == TMO) begin
          m_wb_due = 1; m_err = 1; m_rd = '0; m_data = '0;
          m_granted = 0;
        end else begin
          m_wait++;
        end
      end else begin
        check("mem_req_idle", 32'(bus.mem_req), 32'd0);
        if (bus.req_valid) begin
          c_st = bus.req_is_store; c_f3 = bus.req_funct3; c_addr = bus.req_addr;
          c_wdata = bus.req_wdata; c_rd = bus.req_rd;
          m_busy = 1; m_granted = 0;
          if (!exp_legal(c_st, c_f3, c_addr)) begin
            m_wb_due = 1; m_err = 1; m_rd = '0; m_data = '0;
          end
        end
      end
    end
  end

  // ---------------- transaction driver / memory responder ----------------
  // gnt_dly: cycles of low grant before grant rises; rv_dly: cycles after the
  // first WAIT cycle before rvalid (negative = never).
  // lat counts cycles from the accept edge to the wb_valid cycle.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                     input int gnt_dly, input int rv_dly,
                     output logic [31:0] d, output logic e, output logic [4:0] r, output int lat,
                     output logic [31:0] a1, output logic [3:0] be1, output logic [31:0] wd1,
                     output bit saw_req);
    int g = -1;
    lat = -1; saw_req = 0; d = '0; e = 1'b0; r = '0; a1 = '0; be1 = '0; wd1 = '0;
    @(posedge clk); #1;
    bus.req_is_store = st; bus.req_funct3 = f3; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_rd = rd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      bus.mem_gnt    = (k > gnt_dly);
      bus.mem_rvalid = (g >= 0 && rv_dly >= 0 && k == g + 1 + rv_dly);
      bus.mem_rdata  = rdata;
      @(negedge clk);
      if (k == 1) begin a1 = bus.mem_addr; be1 = bus.mem_be; wd1 = bus.mem_wdata; end
      if (bus.mem_req) saw_req = 1;
      if (bus.mem_req && bus.mem_gnt && g < 0) g = k;
      if (bus.wb_valid) begin
        lat = k; d = bus.wb_data; e = bus.wb_err; r = bus.wb_rd;
      end
      @(posedge clk); #1;
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL wb_seen: got no wb_valid, required one within 60 cycles (addr %08h)", addr);
    end
    $display("txn st=%0d f3=%03b addr=%08h rd=%0d -> lat=%0d err=%0d wb_rd=%0d wb_data=%08h",
             st, f3, addr, rd, lat, e, r, d);
  endtask

  localparam logic [31:0] RD_WORD = 32'h80FF_7F01;

  logic [31:0] d, a1, wd1;
  logic        e;
  logic [4:0]  r;
  logic [3:0]  be1;
  int          lat;
  bit          saw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_mem_be",    32'(bus.mem_be),    32'd0);
    check("rst_mem_addr",  bus.mem_addr,       32'd0);
    check("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
    check("rst_wb_data",   bus.wb_data,        32'd0);

    // misaligned SW -> fault one cycle after accept, no memory access
    txn(1, 3'b010, 32'h1000_0006, 32'hDEAD_BEEF, 5'd7, 32'h0, 0, -1, d, e, r, lat, a1, be1, wd1, saw);
    check("sw_mis_lat", 32'(lat), 32'd1);
    check("sw_mis_err", 32'(e), 32'd1);
    check("sw_mis_rd",  32'(r), 32'd0);
    check("sw_mis_data", d, 32'd0);
    check("sw_mis_nomem", 32'(saw), 32'd0);

    // SB to lane 3
    txn(1, 3'b000, 32'h0000_0103, 32'h1234_56A5, 5'd3, 32'h0, 0, -1, d, e, r, lat, a1, be1, wd1, saw);
    check("sb_addr",  a1, 32'h0000_0100);
    check("sb_be",    32'(be1), 32'h8);
    check("sb_wdata", wd1, 32'hA5A5_A5A5);
    check("sb_lat",   32'(lat), 32'd2);
    check("sb_rd",    32'(r), 32'd0);

    // loads from a fixed word
    txn(0, 3'b000, 32'h0000_2003, 32'h0, 5'd5, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lb_data", d, 32'hFFFF_FF80);
    check("lb_rd",   32'(r), 32'd5);
    check("lb_lat",  32'(lat), 32'd3);
    txn(0, 3'b100, 32'h0000_2003, 32'h0, 5'd6, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lbu_data", d, 32'h0000_0080);
    txn(0, 3'b001, 32'h0000_2002, 32'h0, 5'd7, RD_WORD, 0, 1, d, e, r, lat, a1, be1, wd1, saw);
    check("lh_data", d, 32'hFFFF_80FF);
    check("lh_lat",  32'(lat), 32'd4);
    txn(0, 3'b101, 32'h0000_2000, 32'h0, 5'd8, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lhu_data", d, 32'h0000_7F01);
    txn(0, 3'b010, 32'h0000_2000, 32'h0, 5'd9, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lw_data", d, 32'h80FF_7F01);
    check("lw_rd",   32'(r), 32'd9);
    txn(0, 3'b000, 32'h0000_2001, 32'h0, 5'd0, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lb_x0_data", d, 32'h0000_007F);
    check("lb_x0_rd",   32'(r), 32'd0);

    // grant stall on SH lane 2
    txn(1, 3'b001, 32'h0000_0302, 32'hCAFE_1234, 5'd2, 32'h0, 5, -1, d, e, r, lat, a1, be1, wd1, saw);
    check("sh_stall_be",    32'(be1), 32'hC);
    check("sh_stall_wdata", wd1, 32'h1234_1234);
    check("sh_stall_lat",   32'(lat), 32'd7);

    // illegal encodings and misaligned half
    txn(0, 3'b011, 32'h0000_2000, 32'h0, 5'd4, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("ill_ld_err", 32'(e), 32'd1);
    txn(1, 3'b100, 32'h0000_2000, 32'h0, 5'd4, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("ill_st_err", 32'(e), 32'd1);
    txn(0, 3'b001, 32'h0000_2001, 32'h0, 5'd4, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("lh_mis_err", 32'(e), 32'd1);
    check("lh_mis_lat", 32'(lat), 32'd1);

    // load timeout: WAIT entered at lat 2, fault TMO+1 cycles later
    txn(0, 3'b010, 32'h0000_0040, 32'h0, 5'd11, RD_WORD, 0, -1, d, e, r, lat, a1, be1, wd1, saw);
    check("tmo_err", 32'(e), 32'd1);
    check("tmo_lat", 32'(lat), 32'(2 + TMO + 1));
    check("tmo_rd",  32'(r), 32'd0);
    @(negedge clk);
    check("tmo_ready_after", 32'(bus.req_ready), 32'd1);

    // rvalid in the same cycle the counter reaches the limit wins
    txn(0, 3'b010, 32'h0000_0044, 32'h0, 5'd12, 32'h1357_9BDF, 0, TMO, d, e, r, lat, a1, be1, wd1, saw);
    check("edge_err",  32'(e), 32'd0);
    check("edge_data", d, 32'h1357_9BDF);
    check("edge_lat",  32'(lat), 32'(2 + TMO + 1));

    // reset in the middle of WAIT, followed by a stray rvalid
    @(posedge clk); #1;
    bus.req_is_store = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_2000;
    bus.req_rd = 5'd10; bus.req_valid = 1;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.mem_gnt = 1;
    @(posedge clk); #1;
    bus.mem_gnt = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = RD_WORD;
    @(negedge clk);
    check("rstw_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rstw_ready",    32'(bus.req_ready), 32'd1);
    check("rstw_mem_req",  32'(bus.mem_req),  32'd0);
    check("rstw_mem_addr", bus.mem_addr,      32'd0);
    check("rstw_wb_data",  bus.wb_data,       32'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 0;
    @(negedge clk);
    check("rstw_wb_valid2", 32'(bus.wb_valid), 32'd0);
    $display("txn reset during WAIT, stray rvalid after reset");
    txn(0, 3'b001, 32'h0000_2000, 32'h0, 5'd13, RD_WORD, 0, 0, d, e, r, lat, a1, be1, wd1, saw);
    check("post_rst_data", d, 32'h0000_7F01);
    check("post_rst_rd",   32'(r), 32'd13);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
